// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem responder: FSM states, MMIO addresses
// and the wait-state counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int WCNT_W = 4;

    localparam logic [31:0] MMIO_CYCLE_ADDR = 32'hFFFF_FFF0;
    localparam logic [31:0] MMIO_LED_ADDR   = 32'hFFFF_FFF4;

    function automatic logic [WCNT_W-1:0] wcnt_load(input int ws);
        return WCNT_W'(ws);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed single-port synchronous RAM: one read or one write per cycle,
// registered read data (read-first on a same-address write).
module dmem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_BITS   = 12
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: IDLE/WAIT/RESP request FSM in front of a
// single-port RAM. Optional MMIO (cycle counter, led register) under DMEM_MMIO_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        ready,
    output logic        busy
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] led
`endif
);

    state_e              state_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [31:0]         addr_q;
    logic [31:0]         data_q;
    logic                wren_q;
    logic                ready_q;
    logic                busy_q;
    logic                fresh_q;
    logic [31:0]         qhold_q;

    logic [31:0]         eff_addr;
    logic [31:0]         eff_data;
    logic                eff_wren;
    logic                go_resp;
    logic                is_mmio;
    logic [31:0]         mmio_rdata;
    logic                arr_we;
    logic [31:0]         arr_rdata;

    // With zero wait states the RESP transition happens on the acceptance edge,
    // so the live request inputs feed the RAM; otherwise the captured copies do.
    always_comb begin
        eff_addr = addr_q;
        eff_data = data_q;
        eff_wren = wren_q;
        go_resp  = 1'b0;
        if (state_q == S_IDLE) begin
            eff_addr = address_dmem;
            eff_data = data;
            eff_wren = wren;
            go_resp  = req && (WAIT_STATES == 0);
        end else if (state_q == S_WAIT) begin
            go_resp  = (wcnt_q == WCNT_W'(1));
        end
    end

`ifdef DMEM_MMIO_EN
    logic        is_cyc;
    logic        is_led;
    logic [31:0] cyc_q;
    logic [31:0] led_q;

    assign is_cyc     = (eff_addr == MMIO_CYCLE_ADDR);
    assign is_led     = (eff_addr == MMIO_LED_ADDR);
    assign is_mmio    = is_cyc || is_led;
    assign mmio_rdata = is_cyc ? cyc_q : led_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_q <= '0;
            led_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (go_resp && eff_wren && is_led) begin
                led_q <= eff_data;
            end
        end
    end

    assign led = led_q;
`else
    logic addr_hi_unused;

    assign is_mmio        = 1'b0;
    assign mmio_rdata     = '0;
    assign addr_hi_unused = ^eff_addr[31:ADDR_BITS];
`endif

    // Reset gates the write so an abandoned or same-cycle request never commits.
    assign arr_we = reset && go_resp && eff_wren && !is_mmio;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_BITS  (ADDR_BITS)
    ) u_array (
        .clock(clock),
        .we   (arr_we),
        .addr (eff_addr[ADDR_BITS-1:0]),
        .wdata(eff_data),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fresh_q <= 1'b0;
            qhold_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= address_dmem;
                        data_q  <= data;
                        wren_q  <= wren;
                        wcnt_q  <= wcnt_load(WAIT_STATES);
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    wcnt_q <= wcnt_q - WCNT_W'(1);
                    if (wcnt_q == WCNT_W'(1)) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Array loads present RAM output during RESP, then latch it to hold.
            if (go_resp) begin
                ready_q <= 1'b1;
                if (!eff_wren) begin
                    if (is_mmio) begin
                        qhold_q <= mmio_rdata;
                    end else begin
                        fresh_q <= 1'b1;
                    end
                end
            end
            if (state_q == S_RESP && fresh_q) begin
                qhold_q <= arr_rdata;
                fresh_q <= 1'b0;
            end
        end
    end

    assign q_dmem = fresh_q ? arr_rdata : qhold_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder sitting on the far side of the processor's dmem port: it accepts load/store requests (`address_dmem`, `data`, `wren`) and returns `q_dmem` with a ready handshake. It replaces the zero-latency dmem in the wrapper so the pipeline can be exercised against multi-cycle memory. It holds a word-addressed single-port array and a request FSM with a programmable wait-state counter.

## Interface
- `DEPTH_WORDS`, 4096: array depth in 32-bit words (power of two).
- `ADDR_BITS`, 12: log2(`DEPTH_WORDS`); index = `address_dmem[ADDR_BITS-1:0]`.
- `WAIT_STATES`, 1: extra cycles between acceptance and response (0–15).
- `clock` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-low.
- `req` in 1: requester has a valid load or store this cycle.
- `address_dmem` in 32: word address.
- `data` in 32: store data.
- `wren` in 1: 1 = store, 0 = load; qualified by `req`.
- `q_dmem` out 32: load data, registered.
- `ready` out 1: single-cycle pulse marking completion of the accepted request.
- `busy` out 1: high in every non-IDLE state.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - If `req`=1, capture address, data and `wren` into request registers and load `wcnt` ← `WAIT_STATES`.
  - Next state is WAIT if `WAIT_STATES` > 0, else RESP.
- WAIT:
  - Decrement `wcnt`.
  - When `wcnt`==1, go to RESP.
  - `req`, `address_dmem`, `data` and `wren` are ignored; the captured copies are used.
- Transition into RESP:
  - Store: array[idx] ← captured data.
  - Load: `q_dmem` ← array[idx].
- RESP:
  - `ready`=1 for exactly this cycle, then go to IDLE.
  - `req` is not sampled in RESP.
- Address bits above `ADDR_BITS` are ignored, so addresses alias modulo `DEPTH_WORDS`.
- `q_dmem` holds the last load result; stores never change it.
- Read-after-write to the same address in back-to-back requests returns the new data.
- The requester must stall while `req`=1 and `ready`=0, and must hold or deassert `req` in the cycle after `ready`.
- Reset:
  - Values: state IDLE, `ready`=0, `busy`=0, `q_dmem`=0, `wcnt`=0, request registers 0.
  - Array contents are not cleared.
  - Reset during WAIT abandons the request; a pending store is not committed.
  - Reset in the same cycle as `req` has priority, and the request is not accepted.

## Timing
- Request accepted at edge 0 (IDLE, `req`=1). `ready` is high during cycle `WAIT_STATES`+1, with `q_dmem` valid in that same cycle.
- `WAIT_STATES`=0: `ready` is high in the cycle after acceptance (latency 1).
- Throughput: one request per `WAIT_STATES`+2 cycles, because IDLE is always visited between requests.
- `busy` rises the cycle after acceptance and falls the cycle after `ready`.
- The array is a synchronous single-port RAM: one read or one write per cycle, and there is no combinational path from inputs to outputs.

## Configuration
- `DMEM_MMIO_EN`, when defined:
  - Adds output `led` (32) and a free-running 32-bit cycle counter that is reset to 0 and wraps at 2^32.
  - Full 32-bit address 32'hFFFF_FFF0: loads return the counter value sampled at the RESP transition; stores are dropped.
  - 32'hFFFF_FFF4: load/store of the `led` register, reset value 0.
  - MMIO accesses follow the same FSM and latency and do not touch the array.
- Undefined: no `led` port and no counter; these addresses alias into the array like any other address.

## Structure
- Package `dmem_pkg`:
  - State enum (IDLE, WAIT, RESP).
  - MMIO address constants `MMIO_CYCLE_ADDR` and `MMIO_LED_ADDR`.
  - Width of `wcnt` (4 bits).
- Sub-module `dmem_array`: single-port synchronous RAM, parameterised by `DEPTH_WORDS` and `ADDR_BITS`, with ports `clock`, `we`, `addr`, `wdata`, `rdata`. The FSM, counter and MMIO decode live in `dmem_responder`.

## Test plan
- Reset low for 2 cycles -> `ready`=0, `busy`=0, `q_dmem`=0; after reset release with `req`=0 these stay unchanged.
- `WAIT_STATES`=1: store 32'hDEAD_BEEF to address 5, then load address 5 -> store `ready` 2 cycles after acceptance; load `ready` 2 cycles after its acceptance with `q_dmem`=32'hDEAD_BEEF.
- `WAIT_STATES`=0: alternating store/load back-to-back -> `ready` every second cycle; load returns the value just stored; `q_dmem` is unchanged during stores.
- Aliasing: store 32'h1234 to address 32'h0000_1003, then load 3 (`DEPTH_WORDS`=4096) -> 32'h1234.
- Reset asserted in WAIT of a store of 32'hAAAA to address 7 (`WAIT_STATES`=3), then load 7 -> the old contents are returned, not 32'hAAAA.
- `DMEM_MMIO_EN`: store 32'h5 to 32'hFFFF_FFF4 -> `led`=5 from the RESP cycle onward. Two loads of 32'hFFFF_FFF0 accepted N cycles apart -> their results differ by N.
